// File: rtl/serial_logic_unit.sv
// serial_logic_unit: bit-serial evaluator of eight two-input bitwise functions.
// Operands are latched on start and processed one bit per clock, LSB first,
// under a start/busy/done handshake. Result and zero hold the last completed
// value and change only when an operation finishes.
// Optional build macro SERIAL_LOGIC_UNIT_PARITY_EN adds a parity output
// (XOR-reduction of result), accumulated serially while the operation runs.
module serial_logic_unit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero
`ifdef SERIAL_LOGIC_UNIT_PARITY_EN
    ,
    output logic             parity
`endif
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam int IDX_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [2:0]         op_q;
    logic [WIDTH-1:0]   sh_q;
    logic [WIDTH-1:0]   sh_nxt;
    logic [IDX_W-1:0]   idx;
    logic               bit_v;
    logic               last_bit;
`ifdef SERIAL_LOGIC_UNIT_PARITY_EN
    logic               par_acc_q;
`endif

    // Per-bit boolean function selected by the latched op code.
    function automatic logic eval_bit(input logic [2:0] sel, input logic x, input logic y);
        logic r;
        case (sel)
            3'b000:  r = x & y;
            3'b001:  r = x | y;
            3'b010:  r = ~(x & y);
            3'b011:  r = ~(x | y);
            3'b100:  r = x ^ y;
            3'b101:  r = ~(x ^ y);
            3'b110:  r = x & ~y;
            default: r = ~x & y;
        endcase
        return r;
    endfunction

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: start is only honoured in IDLE; DONE lasts one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (last_bit) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake outputs decoded purely from the registered state.
    always_comb begin
        busy = (state_q == S_RUN);
        done = (state_q == S_DONE);
    end

    // Current bit's function value and the shift register after inserting it.
    always_comb begin
        idx      = cnt_q[IDX_W-1:0];
        last_bit = (cnt_q == LAST_CNT);
        bit_v    = eval_bit(op_q, a_q[idx], b_q[idx]);
        sh_nxt   = {bit_v, sh_q[WIDTH-1:1]};
    end

    // Operand capture, serial shift, and publication of the completed result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            cnt_q     <= '0;
            sh_q      <= '0;
            result    <= '0;
            zero      <= 1'b1;
`ifdef SERIAL_LOGIC_UNIT_PARITY_EN
            par_acc_q <= 1'b0;
            parity    <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        a_q       <= a;
                        b_q       <= b;
                        op_q      <= op;
                        cnt_q     <= '0;
                        sh_q      <= '0;
`ifdef SERIAL_LOGIC_UNIT_PARITY_EN
                        par_acc_q <= 1'b0;
`endif
                    end
                end
                S_RUN: begin
                    sh_q <= sh_nxt;
`ifdef SERIAL_LOGIC_UNIT_PARITY_EN
                    par_acc_q <= par_acc_q ^ bit_v;
`endif
                    if (last_bit) begin
                        cnt_q  <= '0;
                        result <= sh_nxt;
                        zero   <= (sh_nxt == '0);
`ifdef SERIAL_LOGIC_UNIT_PARITY_EN
                        parity <= par_acc_q ^ bit_v;
`endif
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_logic_unit.sv
// Directed testbench for serial_logic_unit at WIDTH=8.
// Parity checks are compiled in only when SERIAL_LOGIC_UNIT_PARITY_EN is defined.
module tb_serial_logic_unit;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         zero;
    logic         parity;

    int n_vec;
    int n_fail;

    serial_logic_unit #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .zero   (zero)
`ifdef SERIAL_LOGIC_UNIT_PARITY_EN
        ,
        .parity (parity)
`endif
    );

`ifndef SERIAL_LOGIC_UNIT_PARITY_EN
    assign parity = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one start pulse and observe until the done pulse has ended.
    // done_at is the negedge index (0 = first negedge after E0) of the first done.
    task automatic do_op(input logic [2:0] f, input logic [W-1:0] xa, input logic [W-1:0] xb,
                         output int busy_n, output int done_n, output int done_at,
                         output logic [W-1:0] r, output logic z, output logic p);
        busy_n  = 0;
        done_n  = 0;
        done_at = -1;
        r = 'x; z = 1'bx; p = 1'bx;
        @(negedge clk);
        start = 1'b1; op = f; a = xa; b = xb;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (busy) busy_n++;
            if (done) begin
                if (done_n == 0) done_at = i;
                done_n++;
                r = result; z = zero; p = parity;
            end else if (done_n > 0) begin
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        n_vec++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_vec++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
        n_vec++; if (result !== 8'h00) begin n_fail++; $display("FAIL reset_result got %h want 00", result); end
        n_vec++; if (zero !== 1'b1) begin n_fail++; $display("FAIL reset_zero got %b want 1", zero); end
`ifdef SERIAL_LOGIC_UNIT_PARITY_EN
        n_vec++; if (parity !== 1'b0) begin n_fail++; $display("FAIL reset_parity got %b want 0", parity); end
`endif
        rst_n = 1'b1;
    endtask

    task automatic test_and_timing();
        int bn, dn, da; logic [W-1:0] r; logic z, p;
        do_op(3'b000, 8'hA5, 8'h0F, bn, dn, da, r, z, p);
        n_vec++; if (bn != 8) begin n_fail++; $display("FAIL and_busy_cycles got %0d want 8", bn); end
        n_vec++; if (dn != 1) begin n_fail++; $display("FAIL and_done_width got %0d want 1", dn); end
        n_vec++; if (da != 8) begin n_fail++; $display("FAIL and_done_at got %0d want 8", da); end
        n_vec++; if (r !== 8'h05) begin n_fail++; $display("FAIL and_result got %h want 05", r); end
        n_vec++; if (z !== 1'b0) begin n_fail++; $display("FAIL and_zero got %b want 0", z); end
    endtask

    task automatic test_andn_nor();
        int bn, dn, da; logic [W-1:0] r; logic z, p;
        do_op(3'b110, 8'hF0, 8'h3C, bn, dn, da, r, z, p);
        n_vec++; if (r !== 8'hC0) begin n_fail++; $display("FAIL andn_result got %h want C0", r); end
        n_vec++; if (dn != 1) begin n_fail++; $display("FAIL andn_done_width got %0d want 1", dn); end
        do_op(3'b011, 8'h00, 8'h00, bn, dn, da, r, z, p);
        n_vec++; if (r !== 8'hFF) begin n_fail++; $display("FAIL nor_result got %h want FF", r); end
        n_vec++; if (z !== 1'b0) begin n_fail++; $display("FAIL nor_zero got %b want 0", z); end
        n_vec++; if (dn != 1) begin n_fail++; $display("FAIL nor_done_width got %0d want 1", dn); end
    endtask

    task automatic test_zero_flag();
        int bn, dn, da; logic [W-1:0] r; logic z, p;
        do_op(3'b100, 8'h5A, 8'h5A, bn, dn, da, r, z, p);
        n_vec++; if (r !== 8'h00) begin n_fail++; $display("FAIL xor_result got %h want 00", r); end
        n_vec++; if (z !== 1'b1) begin n_fail++; $display("FAIL xor_zero got %b want 1", z); end
        do_op(3'b001, 8'h01, 8'h00, bn, dn, da, r, z, p);
        n_vec++; if (r !== 8'h01) begin n_fail++; $display("FAIL or_result got %h want 01", r); end
        n_vec++; if (z !== 1'b0) begin n_fail++; $display("FAIL or_zero got %b want 0", z); end
    endtask

    // Inputs disturbed and start re-pulsed mid-RUN must not affect the operation.
    task automatic test_input_isolation();
        int dn; int hold_bad; logic [W-1:0] r;
        dn = 0; hold_bad = 0; r = 'x;
        @(negedge clk);
        start = 1'b1; op = 3'b000; a = 8'hFF; b = 8'hFF;
        @(negedge clk);
        start = 1'b0;
        if (busy && result !== 8'h01) hold_bad++;
        @(negedge clk);
        start = 1'b1; a = 8'h00; op = 3'b011;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (busy && result !== 8'h01) hold_bad++;
            if (done) begin dn++; r = result; end
            @(negedge clk);
        end
        n_vec++; if (r !== 8'hFF) begin n_fail++; $display("FAIL iso_result got %h want FF", r); end
        n_vec++; if (dn != 1) begin n_fail++; $display("FAIL iso_done_count got %0d want 1", dn); end
        n_vec++; if (hold_bad != 0) begin n_fail++; $display("FAIL iso_result_hold got %0d changes want 0", hold_bad); end
    endtask

    // start held high: operations repeat every WIDTH+2 cycles.
    task automatic test_back_to_back();
        int first, second, seen;
        first = -1; second = -1; seen = 0;
        @(negedge clk);
        start = 1'b1; op = 3'b000; a = 8'hFF; b = 8'h0F;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done) begin
                if (seen == 0) first = i;
                else if (seen == 1) second = i;
                seen++;
            end
        end
        start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (!busy && !done) break;
            @(negedge clk);
        end
        n_vec++; if (first < 0 || second - first != W + 2) begin
            n_fail++; $display("FAIL b2b_period got %0d want %0d", second - first, W + 2); end
        n_vec++; if (result !== 8'h0F) begin n_fail++; $display("FAIL b2b_result got %h want 0F", result); end
    endtask

    task automatic test_async_reset();
        int dn, bn, da; logic [W-1:0] r; logic z, p;
        dn = 0;
        @(negedge clk);
        start = 1'b1; op = 3'b000; a = 8'h3C; b = 8'hFF;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_vec++; if (busy !== 1'b0) begin n_fail++; $display("FAIL arst_busy got %b want 0", busy); end
        n_vec++; if (done !== 1'b0) begin n_fail++; $display("FAIL arst_done got %b want 0", done); end
        n_vec++; if (result !== 8'h00) begin n_fail++; $display("FAIL arst_result got %h want 00", result); end
        n_vec++; if (zero !== 1'b1) begin n_fail++; $display("FAIL arst_zero got %b want 1", zero); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 14; i++) begin
            if (done) dn++;
            @(negedge clk);
        end
        n_vec++; if (dn != 0) begin n_fail++; $display("FAIL arst_no_done got %0d want 0", dn); end
        do_op(3'b101, 8'h0F, 8'h0F, bn, dn, da, r, z, p);
        n_vec++; if (r !== 8'hFF) begin n_fail++; $display("FAIL xnor_result got %h want FF", r); end
        n_vec++; if (dn != 1) begin n_fail++; $display("FAIL xnor_done_width got %0d want 1", dn); end
    endtask

    task automatic test_parity();
        int bn, dn, da; logic [W-1:0] r; logic z, p;
        do_op(3'b000, 8'h07, 8'hFF, bn, dn, da, r, z, p);
        n_vec++; if (r !== 8'h07) begin n_fail++; $display("FAIL par1_result got %h want 07", r); end
`ifdef SERIAL_LOGIC_UNIT_PARITY_EN
        n_vec++; if (p !== 1'b1) begin n_fail++; $display("FAIL par1_parity got %b want 1", p); end
`endif
        do_op(3'b000, 8'h05, 8'hFF, bn, dn, da, r, z, p);
        n_vec++; if (r !== 8'h05) begin n_fail++; $display("FAIL par0_result got %h want 05", r); end
`ifdef SERIAL_LOGIC_UNIT_PARITY_EN
        n_vec++; if (p !== 1'b0) begin n_fail++; $display("FAIL par0_parity got %b want 0", p); end
`endif
    endtask

    initial begin
        n_vec = 0;
        n_fail = 0;
        test_reset();
        test_and_timing();
        test_andn_nor();
        test_zero_flag();
        test_input_isolation();
        test_back_to_back();
        test_async_reset();
        test_parity();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
